atan2_deg: RTL and testbench

Sequential inverse of the degree-domain trig path. It takes a fixed-point vector (x, y) and returns its angle as a signed integer number of degrees, rounded to the nearest degree. This is the counterpart of cos_deg/sin, which map integer degrees to fixed-point values.
It uses iterative CORDIC in vectoring mode, one micro-rotation per clock, with a valid/ready handshake on both sides. It sits in rtl/math beside cos_deg and is used wherever a shape's orientation must be recovered from coordinates.

---
 rtl/atan2_deg_pkg.sv | 34 +++
 rtl/atan2_deg_lut.sv | 27 ++
 rtl/atan2_deg.sv | 132 +++++++++++++
 tb/tb_atan2_deg.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/atan2_deg_pkg.sv
// Shared constants for the degree-domain CORDIC path: sizing defaults, the
// arctangent table in degree fixed-point, and the atan2_deg state encoding.
package atan2_deg_pkg;

  localparam int unsigned FLOAT_BITS   = 32;
  localparam int unsigned FRAC_BITS    = 16;
  localparam int unsigned INT_BITS     = 16;
  localparam int unsigned CORDIC_ITER  = 16;
  localparam int unsigned ATAN_AF      = 16;
  localparam int unsigned ATAN_TBL_LEN = 20;

  // round(atan(2^-i) * 180/pi * 2^ATAN_AF), i = 0..19
  localparam int ATAN_TBL [ATAN_TBL_LEN] = '{
    2949120, 1740967, 919879, 466945, 234379, 117304, 58666, 29335,
    14668,   7334,    3667,   1833,   917,    458,    229,   115,
    57,      29,      14,     7
  };

  function automatic longint deg_to_fx(input int deg, input int unsigned af);
    return longint'(deg) <<< af;
  endfunction

  localparam longint DEG90_FX  = deg_to_fx(90, ATAN_AF);
  localparam longint DEG180_FX = deg_to_fx(180, ATAN_AF);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ITERATE,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/atan2_deg_lut.sv
// Combinational CORDIC arctangent table: index i -> atan(2^-i) in degrees,
// scaled to AF fractional bits.
module atan_deg_lut
  import atan2_deg_pkg::*;
#(
  parameter int unsigned AF = ATAN_AF,
  parameter int unsigned ZW = 9 + AF + 1
) (
  input  logic [4:0]           idx,
  output logic signed [ZW-1:0] angle
);

  logic signed [31:0] raw;

  always_comb begin
    raw = '0;
    if (idx < 5'(ATAN_TBL_LEN)) raw = ATAN_TBL[idx];
  end

  // Table is stored at ATAN_AF fractional bits; rescale with rounding if narrower.
  if (AF >= ATAN_AF) begin : g_widen
    assign angle = ZW'(raw) <<< (AF - ATAN_AF);
  end else begin : g_narrow
    assign angle = ZW'((raw + (32'sd1 <<< (ATAN_AF - AF - 1))) >>> (ATAN_AF - AF));
  end

endmodule

// File: rtl/atan2_deg.sv
// Sequential atan2 in integer degrees: quadrant pre-rotation, ITER CORDIC
// vectoring micro-rotations, then round-half-up to the nearest degree.
module atan2_deg
  import atan2_deg_pkg::*;
#(
  parameter int unsigned W    = FLOAT_BITS,
  parameter int unsigned FRAC = FRAC_BITS,
  parameter int unsigned ITER = CORDIC_ITER,
  parameter int unsigned AF   = ATAN_AF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        x,
  input  logic [W-1:0]        y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INT_BITS-1:0] out,
  output logic                zero
);

  localparam int unsigned XW = W + 2;
  localparam int unsigned ZW = 9 + AF + 1;
  localparam int unsigned IW = 5;

  localparam logic signed [ZW-1:0] Z90  = ZW'(deg_to_fx(90, AF));
  localparam logic signed [ZW-1:0] HALF = ZW'(deg_to_fx(1, AF) >>> 1);
  localparam logic signed [ZW-1:0] D180 = ZW'(180);

  if (ITER < 8 || ITER > 20 || FRAC >= W) begin : g_bad_cfg
    $error("atan2_deg: ITER must be 8..20 and FRAC < W");
  end

  state_t state, next_state;

  logic signed [XW-1:0] xr, yr, xs, ys;
  logic signed [ZW-1:0] zr, a_i, d_rnd;
  logic [IW-1:0]        i;
  logic                 zflag;

  assign xs = xr >>> i;
  assign ys = yr >>> i;

  atan_deg_lut #(.AF(AF), .ZW(ZW)) u_lut (
    .idx   (i),
    .angle (a_i)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = PRE;
      end
      PRE:     next_state = ITERATE;
      ITERATE: if (i == IW'(ITER - 1)) next_state = ROUND;
      ROUND:   next_state = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // An exact -180 result is folded onto +180 so the output range is -179..180.
  always_comb begin
    d_rnd = (zr + HALF) >>> AF;
    if (d_rnd == -D180) d_rnd = D180;
    if (zflag) d_rnd = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xr    <= '0;
      yr    <= '0;
      zr    <= '0;
      i     <= '0;
      zflag <= 1'b0;
      out   <= '0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          xr <= XW'(signed'(x));
          yr <= XW'(signed'(y));
          zr <= '0;
        end
        PRE: begin
          i     <= '0;
          zflag <= (xr == '0) && (yr == '0);
          if (xr[XW-1] && !yr[XW-1]) begin
            xr <= yr;
            yr <= -xr;
            zr <= Z90;
          end else if (xr[XW-1]) begin
            xr <= -yr;
            yr <= xr;
            zr <= -Z90;
          end
        end
        ITERATE: begin
          if (!yr[XW-1]) begin
            xr <= xr + ys;
            yr <= yr - xs;
            zr <= zr + a_i;
          end else begin
            xr <= xr - ys;
            yr <= yr + xs;
            zr <= zr - a_i;
          end
          i <= i + 1'b1;
        end
        ROUND: begin
          out  <= INT_BITS'(d_rnd);
          zero <= zflag;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_atan2_deg.sv
// Directed and randomized checks of atan2_deg using a scoreboard of expected
// angles and a real-valued atan2 reference.
`timescale 1ns/1ps
module tb_atan2_deg;

  localparam real PI = 3.14159265358979323846;

  typedef struct {
    int ang;
    bit zr;
    bit tol;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x, y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        zero;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  int dx [10] = '{0, -65536, 65536, -56756, -65536, -65536, 0, 0, 32'h8000_0000, -65536};
  int dy [10] = '{65536, 0, -65536, 32768, -1, -1200, 0, -65536, 32'h8000_0000, 65536};
  int da [10] = '{90, 180, -45, 150, 180, -179, 0, -90, -135, 135};
  bit dz [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

  atan2_deg #(.W(32), .FRAC(16), .ITER(16), .AF(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_tol(input string tag, input int got, input int exp);
    int diff;
    diff = got - exp;
    if (diff > 180) diff -= 360;
    if (diff < -180) diff += 360;
    compared++;
    assert (diff <= 1 && diff >= -1) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d (+/-1)", tag, got, exp);
    end
  endtask

  task automatic send(input int xi, input int yi, input int ang, input bit zr, input bit tol);
    int n;
    x = xi;
    y = yi;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back('{ang, zr, tol});
  endtask

  task automatic recv(input string tag, input int hold, output int lat, output bit ir_seen);
    exp_t e;
    int n, got;
    logic [15:0] o0;
    logic z0;
    n = 0;
    ir_seen = 1'b0;
    while (!out_valid && n < 200) begin
      ir_seen |= in_ready;
      @(posedge clk); #1;
      n++;
    end
    lat = n;
    check({tag, "_valid"}, int'(out_valid), 1);
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      got = int'($signed(out));
      if (e.tol) check_tol(tag, got, e.ang);
      else       check(tag, got, e.ang);
      check({tag, "_zero"}, int'(zero), int'(e.zr));
    end
    o0 = out;
    z0 = zero;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      x = 0;
      y = -65536;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({tag, "_hold_out"}, int'(out), int'(o0));
      check({tag, "_hold_valid"}, int'(out_valid), 1);
      check({tag, "_hold_zero"}, int'(zero), int'(z0));
      check({tag, "_hold_in_ready"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (hold > 0) begin
      check({tag, "_post_valid"}, int'(out_valid), 0);
      check({tag, "_post_in_ready"}, int'(in_ready), 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    bit irs;
    int xi, yi, ang;
    longint mag;
    real r;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0;
    y = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out", int'(out), 0);
    check("rst_zero", int'(zero), 0);

    send(65536, 0, 0, 0, 0);
    recv("east", 0, lat, irs);
    check("latency", lat, 18);
    check("busy_in_ready", int'(irs), 0);

    for (int k = 0; k < 10; k++) begin
      send(dx[k], dy[k], da[k], dz[k], 0);
      recv($sformatf("dir%0d", k), 0, lat, irs);
    end

    send(65536, 65536, 45, 0, 0);
    recv("backpressure", 5, lat, irs);

    // Reset while ITERATE is on step 7; the in-flight result must vanish.
    send(65536, -65536, -45, 0, 0);
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    void'(sb.pop_back());
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out", int'(out), 0);
    check("midrst_zero", int'(zero), 0);
    repeat (25) begin
      @(posedge clk); #1;
    end
    check("midrst_no_result", int'(out_valid), 0);
    send(-65536, 65536, 135, 0, 0);
    recv("after_rst", 0, lat, irs);

    for (int k = 0; k < 1500; k++) begin
      do begin
        if (k % 2 == 0) begin
          xi = int'($urandom());
          yi = int'($urandom());
        end else begin
          xi = int'($urandom_range(4000, 0)) - 2000;
          yi = int'($urandom_range(4000, 0)) - 2000;
        end
        mag = (xi < 0 ? -longint'(xi) : longint'(xi)) + (yi < 0 ? -longint'(yi) : longint'(yi));
      end while (mag < 16);
      r = $atan2(real'(yi), real'(xi)) * 180.0 / PI;
      ang = int'($floor(r + 0.5));
      if (ang == -180) ang = 180;
      send(xi, yi, ang, 0, 1);
      recv($sformatf("rnd%0d", k), 0, lat, irs);
    end

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
